alu_exec_unit: RTL and testbench

- Parametrised successor to the combinational ALU control decoder: it decodes ALUOp/funct and also executes the operation.
- Adds a valid/ready handshake, registered results, an iterative multi-cycle multiplier, SLT, zero and illegal flags.
- Sits in the EX stage between the ID/EX register and EX/MEM. The pipeline stalls while ready_o is low.

---
 rtl/alu_exec_unit_if.sv | 28 ++
 rtl/alu_exec_unit.sv | 143 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Request/response bus of the EX-stage ALU: operation request in, registered result out.
// The slave modport is the execution unit; the master side is the pipeline driving it.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [1:0]       ALUOp_i;
  logic [5:0]       funct_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             illegal_o;
  logic [3:0]       ALUCtrl_o;

  modport master (
    output valid_i, ALUOp_i, funct_i, a_i, b_i, ready_i,
    input  ready_o, valid_o, result_o, zero_o, illegal_o, ALUCtrl_o
  );

  modport slave (
    input  valid_i, ALUOp_i, funct_i, a_i, b_i, ready_i,
    output ready_o, valid_o, result_o, zero_o, illegal_o, ALUCtrl_o
  );
endinterface

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes ALUOp/funct and executes with registered results and a
// valid/ready handshake; multiply is iterative, retiring MUL_BITS bits per cycle.
//
// state | meaning
// IDLE  | no result pending, ready for a request
// MUL   | iterative multiply in progress, requests blocked
// DONE  | result valid, held until ready_i
module alu_exec_unit #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input logic            clk_i,
  input logic            rst_i,
  alu_exec_unit_if.slave bus
);

  localparam int STEPS = WIDTH / MUL_BITS;
  localparam int CW    = $clog2(STEPS + 1);

  if (MUL_BITS < 1 || WIDTH < 8 || (WIDTH % MUL_BITS) != 0) begin : g_bad_param
    $error("alu_exec_unit: WIDTH must be >= 8 and divisible by MUL_BITS");
  end

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t                  state;
  logic                    valid_q;
  logic [WIDTH-1:0]        result_q;
  logic                    zero_q;
  logic                    illegal_q;
  logic [3:0]              ctrl_q;
  logic [WIDTH-1:0]        acc;
  logic [WIDTH-1:0]        mcand;
  logic [WIDTH-1:0]        mplier;
  logic [CW-1:0]           cnt;

  logic [3:0]              dec_ctrl;
  logic                    dec_illegal;
  logic                    dec_mul;
  logic [WIDTH-1:0]        exec_res;
  logic                    ready;
  logic                    accept;
  logic [WIDTH+MUL_BITS-1:0] pp;

  always_comb begin
    dec_ctrl    = 4'b0000;
    dec_illegal = 1'b0;
    dec_mul     = 1'b0;
    case (bus.ALUOp_i)
      2'b00: dec_ctrl = 4'b0010;
      2'b01: dec_ctrl = 4'b0110;
      2'b10: begin
        case (bus.funct_i)
          6'b100000: dec_ctrl = 4'b0010;
          6'b100010: dec_ctrl = 4'b0110;
          6'b100100: dec_ctrl = 4'b0000;
          6'b100101: dec_ctrl = 4'b0001;
          6'b101010: dec_ctrl = 4'b0111;
          6'b011000: begin
            dec_ctrl = 4'b1010;
            dec_mul  = 1'b1;
          end
          default:   dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Illegal ops decode to ALUCtrl 0000 (same code as AND), so they are masked first.
  always_comb begin
    exec_res = '0;
    if (!dec_illegal) begin
      case (dec_ctrl)
        4'b0010: exec_res = bus.a_i + bus.b_i;
        4'b0110: exec_res = bus.a_i - bus.b_i;
        4'b0000: exec_res = bus.a_i & bus.b_i;
        4'b0001: exec_res = bus.a_i | bus.b_i;
        4'b0111: exec_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a_i) < $signed(bus.b_i))};
        default: exec_res = '0;
      endcase
    end
  end

  assign pp     = {{MUL_BITS{1'b0}}, mcand} * {{WIDTH{1'b0}}, mplier[MUL_BITS-1:0]};
  assign ready  = (state == IDLE) || (state == DONE && bus.ready_i);
  assign accept = bus.valid_i && ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      valid_q   <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
      ctrl_q    <= 4'b0000;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else if (state == MUL) begin
      // One extra cycle at cnt==0 publishes the accumulator, giving STEPS+1 latency.
      if (cnt == '0) begin
        result_q <= acc;
        zero_q   <= (acc == '0);
        valid_q  <= 1'b1;
        state    <= DONE;
      end else begin
        acc    <= acc + pp[WIDTH-1:0];
        mcand  <= mcand << MUL_BITS;
        mplier <= mplier >> MUL_BITS;
        cnt    <= cnt - CW'(1);
      end
    end else if (accept) begin
      ctrl_q    <= dec_ctrl;
      illegal_q <= dec_illegal;
      if (dec_mul) begin
        valid_q <= 1'b0;
        acc     <= '0;
        mcand   <= bus.a_i;
        mplier  <= bus.b_i;
        cnt     <= CW'(STEPS);
        state   <= MUL;
      end else begin
        result_q <= exec_res;
        zero_q   <= (exec_res == '0);
        valid_q  <= 1'b1;
        state    <= DONE;
      end
    end else if (state == DONE && bus.ready_i) begin
      valid_q <= 1'b0;
      state   <= IDLE;
    end
  end

  assign bus.ready_o   = ready;
  assign bus.valid_o   = valid_q;
  assign bus.result_o  = result_q;
  assign bus.zero_o    = zero_q;
  assign bus.illegal_o = illegal_q;
  assign bus.ALUCtrl_o = ctrl_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: one instance with MUL_BITS=1 for most checks,
// a second with MUL_BITS=4 for the radix-16 multiply latency.
module tb_alu_exec_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  alu_exec_unit_if #(.WIDTH(32)) if1 ();
  alu_exec_unit_if #(.WIDTH(32)) if4 ();

  alu_exec_unit #(.WIDTH(32), .MUL_BITS(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));
  alu_exec_unit #(.WIDTH(32), .MUL_BITS(4)) u_dut4 (.clk_i(clk), .rst_i(rst), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req1(input logic [1:0] op, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b);
    if1.valid_i = 1'b1;
    if1.ALUOp_i = op;
    if1.funct_i = fn;
    if1.a_i     = a;
    if1.b_i     = b;
  endtask

  // Counts cycles after the accept edge until valid_o; notes any ready_o while busy.
  task automatic wait_valid(input bit use4, output int cycles, output bit ready_seen);
    logic v, r;
    cycles     = 0;
    ready_seen = 1'b0;
    do begin
      tick();
      cycles++;
      v = use4 ? if4.valid_o : if1.valid_o;
      r = use4 ? if4.ready_o : if1.ready_o;
      if (!v && r) ready_seen = 1'b1;
    end while (!v && cycles < 200);
  endtask

  int cyc;
  bit rdy_seen;
  int bad_hold;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    if1.valid_i = 1'b0; if1.ALUOp_i = 2'b00; if1.funct_i = 6'd0;
    if1.a_i = '0; if1.b_i = '0; if1.ready_i = 1'b1;
    if4.valid_i = 1'b0; if4.ALUOp_i = 2'b00; if4.funct_i = 6'd0;
    if4.a_i = '0; if4.b_i = '0; if4.ready_i = 1'b1;
    tick();
    tick();
    check("rst_valid",   {31'd0, if1.valid_o},   32'd0);
    check("rst_ready",   {31'd0, if1.ready_o},   32'd1);
    check("rst_result",  if1.result_o,           32'd0);
    check("rst_zero",    {31'd0, if1.zero_o},    32'd1);
    check("rst_illegal", {31'd0, if1.illegal_o}, 32'd0);
    check("rst_ctrl",    {28'd0, if1.ALUCtrl_o}, 32'd0);
    rst = 1'b0;
    tick();

    // reset three cycles into a multiply
    req1(2'b10, 6'b011000, 32'd5, 32'd6);
    tick();
    if1.valid_i = 1'b0;
    check("mul_busy_ready", {31'd0, if1.ready_o}, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_valid",  {31'd0, if1.valid_o}, 32'd0);
    check("midrst_ready",  {31'd0, if1.ready_o}, 32'd1);
    check("midrst_result", if1.result_o,         32'd0);
    check("midrst_zero",   {31'd0, if1.zero_o},  32'd1);
    rst = 1'b0;
    req1(2'b00, 6'd0, 32'd1, 32'd1);
    tick();
    if1.valid_i = 1'b0;
    check("postrst_add", if1.result_o,           32'd2);
    check("aluop00_ctrl", {28'd0, if1.ALUCtrl_o}, 32'h2);
    tick();

    // back-to-back single-cycle R-type ops
    req1(2'b10, 6'b100000, 32'd7, 32'd5);
    tick();
    check("add_valid", {31'd0, if1.valid_o}, 32'd1);
    check("add_res",   if1.result_o,         32'd12);
    check("b2b_ready", {31'd0, if1.ready_o}, 32'd1);
    req1(2'b10, 6'b100010, 32'd5, 32'd7);
    tick();
    check("sub_valid", {31'd0, if1.valid_o}, 32'd1);
    check("sub_res",   if1.result_o,         32'hFFFF_FFFE);
    check("sub_ctrl",  {28'd0, if1.ALUCtrl_o}, 32'h6);
    req1(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1);
    tick();
    check("slt_valid", {31'd0, if1.valid_o}, 32'd1);
    check("slt_res",   if1.result_o,         32'd1);
    check("slt_ctrl",  {28'd0, if1.ALUCtrl_o}, 32'h7);
    req1(2'b10, 6'b100101, 32'h0000_00F0, 32'h0000_000F);
    tick();
    check("or_valid", {31'd0, if1.valid_o}, 32'd1);
    check("or_res",   if1.result_o,         32'h0000_00FF);
    check("or_ctrl",  {28'd0, if1.ALUCtrl_o}, 32'h1);
    req1(2'b10, 6'b100100, 32'h0000_0FF0, 32'h0000_00FF);
    tick();
    if1.valid_i = 1'b0;
    check("and_res",  if1.result_o,           32'h0000_00F0);
    check("and_ctrl", {28'd0, if1.ALUCtrl_o}, 32'h0);
    tick();
    check("idle_valid", {31'd0, if1.valid_o}, 32'd0);

    // radix-2 multiply; operands are scrambled after accept
    req1(2'b10, 6'b011000, 32'h0001_0000, 32'h0001_0001);
    tick();
    req1(2'b01, 6'd0, 32'hDEAD_BEEF, 32'h1234_5678);
    wait_valid(1'b0, cyc, rdy_seen);
    if1.valid_i = 1'b0;
    check("mul1_latency", cyc,                   32'd33);
    check("mul1_res",     if1.result_o,          32'h0001_0000);
    check("mul1_busy",    {31'd0, rdy_seen},     32'd0);
    check("mul1_ctrl",    {28'd0, if1.ALUCtrl_o}, 32'hA);
    tick();

    // radix-16 multiply on the second instance
    if4.valid_i = 1'b1; if4.ALUOp_i = 2'b10; if4.funct_i = 6'b011000;
    if4.a_i = 32'hFFFF_FFFD; if4.b_i = 32'd7;
    tick();
    if4.valid_i = 1'b0; if4.a_i = '0; if4.b_i = '0;
    wait_valid(1'b1, cyc, rdy_seen);
    check("mul4_latency", cyc,               32'd9);
    check("mul4_res",     if4.result_o,      32'hFFFF_FFEB);
    check("mul4_busy",    {31'd0, rdy_seen}, 32'd0);
    tick();

    // backpressure: 2+2 held for five cycles, queued request waits for release
    if1.ready_i = 1'b0;
    req1(2'b00, 6'd0, 32'd2, 32'd2);
    tick();
    req1(2'b01, 6'd0, 32'd9, 32'd9);
    bad_hold = 0;
    for (int i = 0; i < 5; i++) begin
      if (if1.valid_o !== 1'b1 || if1.result_o !== 32'd4 || if1.ready_o !== 1'b0)
        bad_hold++;
      tick();
    end
    check("bp_hold_errs", bad_hold,           32'd0);
    check("bp_result",    if1.result_o,       32'd4);
    if1.ready_i = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, if1.ready_o}, 32'd1);
    tick();
    if1.valid_i = 1'b0;
    check("beq_res",   if1.result_o,           32'd0);
    check("beq_zero",  {31'd0, if1.zero_o},    32'd1);
    check("beq_ctrl",  {28'd0, if1.ALUCtrl_o}, 32'h6);
    tick();

    // illegal decodes
    req1(2'b11, 6'b100000, 32'd3, 32'd4);
    tick();
    check("op11_illegal", {31'd0, if1.illegal_o}, 32'd1);
    check("op11_res",     if1.result_o,           32'd0);
    check("op11_ctrl",    {28'd0, if1.ALUCtrl_o}, 32'h0);
    check("op11_valid",   {31'd0, if1.valid_o},   32'd1);
    req1(2'b10, 6'b000000, 32'd3, 32'd4);
    tick();
    check("funct0_illegal", {31'd0, if1.illegal_o}, 32'd1);
    check("funct0_res",     if1.result_o,           32'd0);
    req1(2'b00, 6'd0, 32'd3, 32'd4);
    tick();
    if1.valid_i = 1'b0;
    check("legal_after_illegal", {31'd0, if1.illegal_o}, 32'd0);
    check("legal_add_res",       if1.result_o,           32'd7);
    check("legal_add_zero",      {31'd0, if1.zero_o},    32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
